// File: rtl/minesweeper_ctrl_n.sv
// Minesweeper game controller: owns bomb/reveal/flag/cursor grids and
// win/lose status. Bombs are placed by a Galois LFSR after a restart, then
// the player moves a wrap-around cursor, flags cells and reveals them.
module minesweeper_ctrl_n #(
  parameter  int GRID_W    = 4,
  parameter  int GRID_H    = 4,
  parameter  int NUM_BOMBS = 3,
  localparam int N         = GRID_W * GRID_H,
  localparam int IDX_W     = $clog2(N),
  localparam int RW        = $clog2(GRID_H),
  localparam int CW        = $clog2(GRID_W)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             restart,
  input  logic             confirm,
  input  logic             flag,
  input  logic [3:0]       udlr,
  input  logic [15:0]      seed,
  output logic [N-1:0]     bomb_grid,
  output logic [N-1:0]     reveal_grid,
  output logic [N-1:0]     flag_grid,
  output logic [N-1:0]     cursor_grid,
  output logic [RW-1:0]    cursor_row,
  output logic [CW-1:0]    cursor_col,
  output logic [IDX_W:0]   reveal_count,
  output logic             busy,
  output logic             win,
  output logic             lose
);

  typedef enum logic [2:0] {S_IDLE, S_PLACE, S_PLAY, S_WIN, S_LOSE} state_t;

  state_t           state, state_nxt;
  logic             restart_q, confirm_q, flag_q;
  logic [3:0]       udlr_q;
  logic [15:0]      lfsr, lfsr_nxt;
  logic [IDX_W:0]   bomb_cnt;

  // Rising-edge events; udlr counts as one event when it leaves all-zero.
  logic rst_ev, cf_ev, fl_ev, ud_ev;
  assign rst_ev = restart & ~restart_q;
  assign cf_ev  = confirm & ~confirm_q;
  assign fl_ev  = flag & ~flag_q;
  assign ud_ev  = (|udlr) & ~(|udlr_q);

  // Galois LFSR, taps x^16+x^14+x^13+x^11+1, shifting right.
  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // Placement candidate is taken from the LFSR value before the advance.
  logic [IDX_W-1:0] cand;
  logic [N-1:0]     cand_oh;
  logic             cand_ok;
  assign cand    = lfsr[IDX_W-1:0];
  assign cand_oh = N'(1) << cand;
  assign cand_ok = ({1'b0, cand} < (IDX_W+1)'(N)) && ~|(bomb_grid & cand_oh)
                   && (cand != '0);

  // Properties of the cell under the cursor.
  logic cur_bomb, cur_rev, cur_flag;
  assign cur_bomb = |(bomb_grid & cursor_grid);
  assign cur_rev  = |(reveal_grid & cursor_grid);
  assign cur_flag = |(flag_grid & cursor_grid);

  logic [IDX_W:0] rc_inc;
  assign rc_inc = reveal_count + 1'b1;

  // Wrapped cursor target for the current udlr value.
  logic [RW-1:0]    row_nxt;
  logic [CW-1:0]    col_nxt;
  logic [IDX_W-1:0] cur_idx_nxt;
  always_comb begin
    row_nxt = cursor_row;
    col_nxt = cursor_col;
    case (udlr)
      4'b1000: row_nxt = (cursor_row == '0) ? RW'(GRID_H-1) : cursor_row - 1'b1;
      4'b0100: row_nxt = (cursor_row == RW'(GRID_H-1)) ? '0 : cursor_row + 1'b1;
      4'b0010: col_nxt = (cursor_col == '0) ? CW'(GRID_W-1) : cursor_col - 1'b1;
      4'b0001: col_nxt = (cursor_col == CW'(GRID_W-1)) ? '0 : cursor_col + 1'b1;
      default: ;
    endcase
    cur_idx_nxt = IDX_W'(row_nxt) * IDX_W'(GRID_W) + IDX_W'(col_nxt);
  end

  // Next state and the single action taken this cycle.
  logic place_set, do_reveal, do_flag, do_move, hit_bomb;
  always_comb begin
    state_nxt = state;
    place_set = 1'b0;
    do_reveal = 1'b0;
    do_flag   = 1'b0;
    do_move   = 1'b0;
    hit_bomb  = 1'b0;
    if (rst_ev) begin
      state_nxt = S_PLACE;
    end else begin
      case (state)
        S_PLACE: if (cand_ok) begin
          place_set = 1'b1;
          if (bomb_cnt == (IDX_W+1)'(NUM_BOMBS-1)) state_nxt = S_PLAY;
        end
        S_PLAY: begin
          if (cf_ev) begin
            // Flagged or already-open cells swallow the confirm.
            if (!cur_flag && !cur_rev) begin
              do_reveal = 1'b1;
              if (cur_bomb) begin
                hit_bomb  = 1'b1;
                state_nxt = S_LOSE;
              end else if (rc_inc == (IDX_W+1)'(N-NUM_BOMBS)) begin
                state_nxt = S_WIN;
              end
            end
          end else if (fl_ev) begin
            do_flag = ~cur_rev;
          end else if (ud_ev) begin
            do_move = $onehot(udlr);
          end
        end
        default: ;
      endcase
    end
  end

  // State register; status outputs follow the state being entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      win   <= 1'b0;
      lose  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_PLACE);
      win   <= (state_nxt == S_WIN);
      lose  <= (state_nxt == S_LOSE);
    end
  end

  // Previous-cycle input copies for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      restart_q <= 1'b0;
      confirm_q <= 1'b0;
      flag_q    <= 1'b0;
      udlr_q    <= 4'b0;
    end else begin
      restart_q <= restart;
      confirm_q <= confirm;
      flag_q    <= flag;
      udlr_q    <= udlr;
    end
  end

  // Board datapath: restart clear, bomb placement, reveal, flag, cursor.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bomb_grid    <= '0;
      reveal_grid  <= '0;
      flag_grid    <= '0;
      cursor_grid  <= '0;
      cursor_row   <= '0;
      cursor_col   <= '0;
      reveal_count <= '0;
      bomb_cnt     <= '0;
      lfsr         <= 16'h0001;
    end else if (rst_ev) begin
      bomb_grid    <= '0;
      reveal_grid  <= '0;
      flag_grid    <= '0;
      cursor_grid  <= N'(1);
      cursor_row   <= '0;
      cursor_col   <= '0;
      reveal_count <= '0;
      bomb_cnt     <= '0;
      lfsr         <= (seed == 16'h0000) ? 16'h0001 : seed;
    end else begin
      if (state == S_PLACE) lfsr <= lfsr_nxt;
      if (place_set) begin
        bomb_grid <= bomb_grid | cand_oh;
        bomb_cnt  <= bomb_cnt + 1'b1;
      end
      if (do_reveal) begin
        reveal_grid <= reveal_grid | cursor_grid | (hit_bomb ? bomb_grid : '0);
        if (!hit_bomb) reveal_count <= rc_inc;
      end
      if (do_flag) flag_grid <= flag_grid ^ cursor_grid;
      if (do_move) begin
        cursor_row  <= row_nxt;
        cursor_col  <= col_nxt;
        cursor_grid <= N'(1) << cur_idx_nxt;
      end
    end
  end

endmodule

// File: tb/tb_minesweeper_ctrl_n.sv
// Bench for minesweeper_ctrl_n: directed game scenarios plus random play,
// every cycle compared against a cell-array model of the game rules.
module tb_minesweeper_ctrl_n;
  localparam int W = 4, H = 4, NB = 3;
  localparam int N = W * H;
  localparam int IDX_W = $clog2(N);
  localparam int RW = $clog2(H), CW = $clog2(W);
  localparam int M_IDLE = 0, M_PLACE = 1, M_PLAY = 2, M_WIN = 3, M_LOSE = 4;

  logic clock = 1'b0, reset = 1'b0;
  logic restart = 0, confirm = 0, flag = 0;
  logic [3:0] udlr = 0;
  logic [15:0] seed = 0;
  logic [N-1:0] bomb_grid, reveal_grid, flag_grid, cursor_grid;
  logic [RW-1:0] cursor_row;
  logic [CW-1:0] cursor_col;
  logic [IDX_W:0] reveal_count;
  logic busy, win, lose;

  minesweeper_ctrl_n #(.GRID_W(W), .GRID_H(H), .NUM_BOMBS(NB)) dut (
    .clock(clock), .reset(reset), .restart(restart), .confirm(confirm),
    .flag(flag), .udlr(udlr), .seed(seed), .bomb_grid(bomb_grid),
    .reveal_grid(reveal_grid), .flag_grid(flag_grid), .cursor_grid(cursor_grid),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .reveal_count(reveal_count),
    .busy(busy), .win(win), .lose(lose));

  always #5 clock = ~clock;

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_st, m_r, m_c, m_cnt, m_bc;
  bit m_curv;
  bit m_bomb[N], m_rev[N], m_flg[N];
  bit [15:0] m_lfsr;
  bit p_rs, p_cf, p_fl;
  bit [3:0] p_ud;

  task automatic model_reset();
    m_st = M_IDLE; m_r = 0; m_c = 0; m_cnt = 0; m_bc = 0; m_curv = 0;
    m_lfsr = 16'h0001;
    for (int i = 0; i < N; i++) begin m_bomb[i] = 0; m_rev[i] = 0; m_flg[i] = 0; end
    p_rs = 0; p_cf = 0; p_fl = 0; p_ud = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit e_rs, e_cf, e_fl, e_ud;
    int cand, i;
    if (!reset) begin model_reset(); return; end
    e_rs = restart && !p_rs;
    e_cf = confirm && !p_cf;
    e_fl = flag && !p_fl;
    e_ud = (udlr != 0) && (p_ud == 0);
    if (e_rs) begin
      for (int k = 0; k < N; k++) begin m_bomb[k] = 0; m_rev[k] = 0; m_flg[k] = 0; end
      m_st = M_PLACE; m_r = 0; m_c = 0; m_cnt = 0; m_bc = 0; m_curv = 1;
      m_lfsr = (seed == 0) ? 16'h0001 : seed;
    end else if (m_st == M_PLACE) begin
      cand = int'(m_lfsr) % (1 << IDX_W);
      if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
      else           m_lfsr = m_lfsr >> 1;
      if (cand < N && cand != 0 && !m_bomb[cand]) begin
        m_bomb[cand] = 1;
        m_bc++;
        if (m_bc == NB) m_st = M_PLAY;
      end
    end else if (m_st == M_PLAY) begin
      i = m_r * W + m_c;
      if (e_cf) begin
        if (!m_flg[i] && !m_rev[i]) begin
          m_rev[i] = 1;
          if (m_bomb[i]) begin
            for (int k = 0; k < N; k++) if (m_bomb[k]) m_rev[k] = 1;
            m_st = M_LOSE;
          end else begin
            m_cnt++;
            if (m_cnt == N - NB) m_st = M_WIN;
          end
        end
      end else if (e_fl) begin
        if (!m_rev[i]) m_flg[i] = !m_flg[i];
      end else if (e_ud) begin
        case (udlr)
          4'b1000: m_r = (m_r + H - 1) % H;
          4'b0100: m_r = (m_r + 1) % H;
          4'b0010: m_c = (m_c + W - 1) % W;
          4'b0001: m_c = (m_c + 1) % W;
          default: ;
        endcase
      end
    end
    p_rs = restart; p_cf = confirm; p_fl = flag; p_ud = udlr;
  endtask

  task automatic compare_all();
    logic [N-1:0] eb, er, ef, ec;
    for (int i = 0; i < N; i++) begin eb[i] = m_bomb[i]; er[i] = m_rev[i]; ef[i] = m_flg[i]; end
    ec = '0;
    if (m_curv) ec[m_r * W + m_c] = 1'b1;
    chk("bomb_grid", bomb_grid, eb);
    chk("reveal_grid", reveal_grid, er);
    chk("flag_grid", flag_grid, ef);
    chk("cursor_grid", cursor_grid, ec);
    chk("cursor_row", cursor_row, m_r);
    chk("cursor_col", cursor_col, m_c);
    chk("reveal_count", reveal_count, m_cnt);
    chk("busy", busy, m_st == M_PLACE);
    chk("win", win, m_st == M_WIN);
    chk("lose", lose, m_st == M_LOSE);
  endtask

  // One clock: drive inputs at a falling edge, check at the next one.
  task automatic cyc(input logic rs, input logic cf, input logic fl, input logic [3:0] ud);
    restart = rs; confirm = cf; flag = fl; udlr = ud;
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic press(input logic cf, input logic fl, input logic [3:0] ud);
    cyc(0, cf, fl, ud);
    cyc(0, 0, 0, 0);
  endtask

  task automatic goto_cell(input int r, input int c);
    while (m_r != r) press(0, 0, 4'b0100);
    while (m_c != c) press(0, 0, 4'b0001);
  endtask

  task automatic start_game(input logic [15:0] s);
    int k;
    seed = s;
    cyc(1, 0, 0, 0);
    chk("busy_rise", busy, 1'b1);
    k = 0;
    while (busy && k < 200) begin cyc(0, 0, 0, 0); k++; end
    chk("busy_fall", busy, 1'b0);
    chk("popcount", $countones(bomb_grid), NB);
    chk("cell0_safe", bomb_grid[0], 1'b0);
    chk("cursor_home", cursor_grid, 1);
  endtask

  task automatic async_reset();
    reset = 1'b0;
    model_step();
    #1;
    compare_all();
    @(negedge clock);
    compare_all();
    reset = 1'b1;
  endtask

  logic [N-1:0] bomb_ref, rev_before;
  int bidx, first_safe;

  initial begin
    model_reset();
    @(negedge clock);
    compare_all();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    press(1, 0, 0);
    press(0, 0, 4'b1000);
    press(0, 1, 0);
    chk("idle_cursor", cursor_grid, 0);

    // Placement and cursor wrap
    start_game(16'hACE1);
    bomb_ref = bomb_grid;
    press(0, 0, 4'b1000);
    chk("up_row", cursor_row, 3);
    chk("up_grid", cursor_grid, 16'h1000);
    press(0, 0, 4'b0010);
    chk("left_col", cursor_col, 3);
    chk("left_grid", cursor_grid, 16'h8000);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 4'b0001);
    cyc(0, 0, 0, 0);
    chk("hold_right", cursor_col, 0);

    // Flag protects a bomb; unflag then confirm loses
    bidx = 0;
    for (int i = N - 1; i >= 0; i--) if (m_bomb[i]) bidx = i;
    goto_cell(bidx / W, bidx % W);
    press(0, 1, 0);
    rev_before = reveal_grid;
    press(1, 0, 0);
    chk("flag_guard_rev", reveal_grid, rev_before);
    chk("flag_guard_lose", lose, 0);
    press(0, 1, 0);
    cyc(0, 1, 0, 0);
    chk("lose_edge", lose, 1);
    chk("bombs_shown", reveal_grid & bomb_grid, bomb_grid);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1'($urandom), 1'($urandom), 4'($urandom));

    // Same seed, reveal every safe cell (one repeat confirm)
    start_game(16'hACE1);
    chk("same_seed", bomb_grid, bomb_ref);
    first_safe = -1;
    for (int i = 0; i < N; i++) begin
      if (!m_bomb[i]) begin
        goto_cell(i / W, i % W);
        press(1, 0, 0);
        if (first_safe < 0) begin
          first_safe = i;
          press(1, 0, 0);
          chk("repeat_count", reveal_count, 1);
        end
      end
    end
    chk("win_count", reveal_count, N - NB);
    chk("win_flag", win, 1);

    // Restart from WIN, then reset in the middle of placement
    seed = 16'h1234;
    cyc(1, 0, 0, 0);
    chk("restart_from_win", busy, 1);
    async_reset();
    chk("reset_busy", busy, 0);
    chk("reset_bombs", bomb_grid, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    start_game(16'h0000);

    // Random play
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) async_reset();
      seed = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      cyc($urandom_range(0, 79) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 5) == 0,
          ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
